// File: rtl/dp_pkg.sv
// Shared types and opcode helpers for the DP ALU sink sequencer.
//   ctl_e       : the 14 legal ALU opcodes (4'hE and 4'hF are illegal)
//   rsp_err_e   : response status code
//   seq_state_e : sequencer FSM states
//   is_legal()  : opcode is one the source understands
//   is_long()   : opcode whose result arrives one cycle later than the rest
package dp_pkg;

   typedef enum logic [3:0] {
      CtlOp0 = 4'h0, CtlOp1 = 4'h1, CtlOp2 = 4'h2, CtlOp3 = 4'h3,
      CtlOp4 = 4'h4, CtlOp5 = 4'h5, CtlOp6 = 4'h6, CtlOp7 = 4'h7,
      CtlOp8 = 4'h8, CtlOp9 = 4'h9, CtlOpA = 4'hA, CtlOpB = 4'hB,
      CtlOpC = 4'hC, CtlOpD = 4'hD
   } ctl_e;

   typedef enum logic [1:0] {
      RspOk      = 2'b00,
      RspNoValid = 2'b01,
      RspIllegal = 2'b10
   } rsp_err_e;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StChk1,
      StChk2,
      StResp
   } seq_state_e;

   function automatic logic is_legal(input logic [3:0] ctl);
      return (ctl <= CtlOpD);
   endfunction

   function automatic logic is_long(input logic [3:0] ctl);
      return (ctl == CtlOp6) || (ctl == CtlOp9);
   endfunction

endpackage

// File: rtl/dp_sat_counter.sv
// Saturating up-counter used for the sequencer debug counters.
//   clk   : clock
//   reset : asynchronous active-low reset
//   inc   : add one (ignored once all-ones is reached)
//   clr   : synchronous clear, wins over inc
//   count : current value
module dp_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign count = r_count;

endmodule

// File: rtl/dp_sink_seq.sv
// Sink-side sequencer for the DP ALU source. Takes one command at a time from
// the cmd channel, issues it to the source with a one-cycle valid_in strobe,
// samples the result on the opcode-dependent edge, and returns a tagged
// response on the rsp channel.
//   clk, reset                       : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_a/b/cin/ctl : upstream command channel
//   ctl, a, b, cin, valid_in         : registered drive to the source
//   valid_out, alu, carry, zero      : source result (zero passed through as-is)
//   rsp_valid/ready, rsp_*           : downstream response channel
//   op_count, err_count              : saturating debug counters
module dp_sink_seq
   import dp_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_a,
   input  logic [3:0]       cmd_b,
   input  logic             cmd_cin,
   input  logic [3:0]       cmd_ctl,
   output logic [3:0]       ctl,
   output logic [3:0]       a,
   output logic [3:0]       b,
   output logic             cin,
   output logic             valid_in,
   input  logic             valid_out,
   input  logic [3:0]       alu,
   input  logic             carry,
   input  logic             zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [3:0]       rsp_alu,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic [3:0]       rsp_ctl,
   output logic [1:0]       rsp_err,
   output logic [CNT_W-1:0] op_count,
   output logic [CNT_W-1:0] err_count
);

   seq_state_e r_state, w_state_d;
   logic       r_cmd_ready, r_valid_in, r_rsp_valid;
   logic [3:0] r_ctl, r_a, r_b, r_rsp_alu, r_rsp_ctl;
   logic       r_cin, r_rsp_carry, r_rsp_zero;
   rsp_err_e   r_rsp_err;
   logic       w_accept, w_sample, w_rsp_hs;

   // r_cmd_ready is low for the first cycle after reset even though the FSM
   // is idle, so every output really is zero while reset is applied.
   assign w_accept = (r_state == StIdle) && r_cmd_ready && cmd_valid;
   assign w_rsp_hs = r_rsp_valid && rsp_ready;
   // Result sample edge: end of CHK1 for short opcodes, end of CHK2 for long.
   assign w_sample = ((r_state == StChk1) && !is_long(r_ctl)) || (r_state == StChk2);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_d = is_legal(cmd_ctl) ? StIssue : StResp;
         StIssue: w_state_d = StChk1;
         StChk1:  w_state_d = is_long(r_ctl) ? StChk2 : StResp;
         StChk2:  w_state_d = StResp;
         StResp:  if (w_rsp_hs) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_cmd_ready <= 1'b0;
         r_valid_in  <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_ctl       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_cin       <= 1'b0;
         r_rsp_alu   <= '0;
         r_rsp_carry <= 1'b0;
         r_rsp_zero  <= 1'b0;
         r_rsp_ctl   <= '0;
         r_rsp_err   <= RspOk;
      end else begin
         r_state     <= w_state_d;
         // Flag outputs are decoded from the next state so they line up with it.
         r_cmd_ready <= (w_state_d == StIdle);
         r_valid_in  <= (w_state_d == StIssue);
         r_rsp_valid <= (w_state_d == StResp);
         if (w_accept) begin
            r_rsp_ctl <= cmd_ctl;
            if (is_legal(cmd_ctl)) begin
               r_ctl <= cmd_ctl;
               r_a   <= cmd_a;
               r_b   <= cmd_b;
               r_cin <= cmd_cin;
            end else begin
               // Illegal opcode never reaches the source pins.
               r_rsp_alu   <= '0;
               r_rsp_carry <= 1'b0;
               r_rsp_zero  <= 1'b0;
               r_rsp_err   <= RspIllegal;
            end
         end
         if (w_sample) begin
            r_rsp_alu   <= alu;
            r_rsp_carry <= carry;
            r_rsp_zero  <= zero;
            r_rsp_err   <= valid_out ? RspOk : RspNoValid;
         end
      end
   end

   dp_sat_counter #(.W(CNT_W)) u_op_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_rsp_hs),
      .clr   (1'b0),
      .count (op_count)
   );

   dp_sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_rsp_hs && (r_rsp_err != RspOk)),
      .clr   (1'b0),
      .count (err_count)
   );

   assign cmd_ready = r_cmd_ready;
   assign ctl       = r_ctl;
   assign a         = r_a;
   assign b         = r_b;
   assign cin       = r_cin;
   assign valid_in  = r_valid_in;
   assign rsp_valid = r_rsp_valid;
   assign rsp_alu   = r_rsp_alu;
   assign rsp_carry = r_rsp_carry;
   assign rsp_zero  = r_rsp_zero;
   assign rsp_ctl   = r_rsp_ctl;
   assign rsp_err   = r_rsp_err;

endmodule
